cache_controller_wbuf: RTL and testbench

- Next-generation data-cache controller between the MEM stage and the SRAM controller.
- Read path: read hits return in the request cycle; read misses fetch a full LINE_WORDS-word line from SRAM, fill the cache and forward the requested word.
- Write path: write-through with no allocate. Writes are posted into a WBUF_DEPTH-entry write buffer so the pipeline does not stall on SRAM write latency.
- The buffer drains to SRAM in the background; a read miss waits until the buffer is empty before fetching.

---
 rtl/cache_ctrl_pkg.sv | 28 ++
 rtl/cache_controller_wbuf_if.sv | 48 ++++
 rtl/write_buffer_fifo.sv | 66 ++++++
 rtl/cache_controller_wbuf.sv | 194 +++++++++++++++++++
 tb/tb_cache_controller_wbuf.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the write-through data-cache controller.
//   read_state_t  : read/fill FSM states
//   write_state_t : write-buffer drain FSM states
//   DEFAULT_ADDR_OFFSET : base subtracted from CPU addresses before indexing
//   line_align()  : clears the in-line offset bits of a byte address
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DRAIN,
    FILL
  } read_state_t;

  typedef enum logic {
    W_IDLE,
    W_BUSY
  } write_state_t;

  localparam int DEFAULT_ADDR_OFFSET = 1024;

  // Works on a 64-bit container so any address width up to 64 can use it;
  // callers zero-extend on the way in and slice on the way out.
  function automatic logic [63:0] line_align(input logic [63:0] addr,
                                             input int unsigned off_bits);
    return addr & ~((64'd1 << off_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_controller_wbuf_if.sv
// Bus bundle for cache_controller_wbuf: CPU (MEM stage) request side,
// cache array side and SRAM controller side.
//   slave  : the controller (drives ready/readData, cache strobes, SRAM strobes)
//   master : the environment (CPU, cache array and SRAM controller)
interface cache_controller_wbuf_if #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LINE_WORDS   = 2,
  parameter int CACHE_ADDR_W = 17
);
  // CPU side
  logic                         MEM_R_EN;
  logic                         MEM_W_EN;
  logic [ADDR_W-1:0]            address;
  logic [DATA_W-1:0]            writeData;
  logic                         ready;
  logic [DATA_W-1:0]            readData;
  // cache array side
  logic                         Cache_Hit;
  logic [DATA_W-1:0]            CacheReadData;
  logic                         Cache_RE;
  logic                         Cache_WE;
  logic                         Cache_Inv;
  logic [CACHE_ADDR_W-1:0]      CacheAddress;
  logic [LINE_WORDS*DATA_W-1:0] CacheWriteData;
  // SRAM controller side
  logic                         SRAM_Ready;
  logic [LINE_WORDS*DATA_W-1:0] SRAM_Read_Data;
  logic                         SRAM_RE;
  logic                         SRAM_WE;
  logic [ADDR_W-1:0]            SRAM_Address;
  logic [DATA_W-1:0]            SRAM_Write_Data;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, address, writeData,
           Cache_Hit, CacheReadData, SRAM_Ready, SRAM_Read_Data,
    output ready, readData, Cache_RE, Cache_WE, Cache_Inv, CacheAddress,
           CacheWriteData, SRAM_RE, SRAM_WE, SRAM_Address, SRAM_Write_Data
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, address, writeData,
           Cache_Hit, CacheReadData, SRAM_Ready, SRAM_Read_Data,
    input  ready, readData, Cache_RE, Cache_WE, Cache_Inv, CacheAddress,
           CacheWriteData, SRAM_RE, SRAM_WE, SRAM_Address, SRAM_Write_Data
  );

endinterface

// File: rtl/write_buffer_fifo.sv
// Posted-write buffer: a power-of-two deep FIFO of {address, data} entries.
//   clk, rst   : clock, asynchronous active-high reset (empties the buffer)
//   push/pop   : enqueue push_data / dequeue head (ignored when full / empty)
//   head       : oldest entry, valid when !empty
//   full/empty : derived from the registered count
//   count      : number of valid entries, 0..DEPTH
module write_buffer_fifo
  import cache_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only read after it
  // has been written, and the pointers/count already define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/cache_controller_wbuf.sv
// Write-through, no-allocate data-cache controller with a posted write buffer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : CPU request/response, cache array strobes and SRAM controller
//              handshake (see cache_controller_wbuf_if)
// Read hits complete in the request cycle. Read misses wait for the write
// buffer to drain, then fetch a whole line, fill the cache and forward the
// requested word. Writes are pushed into the buffer (invalidating the cached
// line) and drained to SRAM one word at a time in the background.
module cache_controller_wbuf
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LINE_WORDS   = 2,
  parameter int CACHE_ADDR_W = 17,
  parameter int ADDR_OFFSET  = DEFAULT_ADDR_OFFSET,
  parameter int WBUF_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_controller_wbuf_if.slave bus
);

  localparam int WSEL_W     = $clog2(LINE_WORDS);
  localparam int LINE_OFF_W = WSEL_W + 2;
  localparam int ENTRY_W    = ADDR_W + DATA_W;
  localparam int CNT_W      = $clog2(WBUF_DEPTH) + 1;

  read_state_t  rstate, rnext;
  write_state_t wstate, wnext;

  // ---------------------------------------------------------------- address
  logic [ADDR_W-1:0] gen_addr;
  logic [WSEL_W-1:0] word_sel;
  logic [63:0]       aligned_wide;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_word;

  // Word-aligned, offset-relative address; wraps modulo 2^ADDR_W.
  assign gen_addr     = {bus.address[ADDR_W-1:2], 2'b00} - ADDR_W'(ADDR_OFFSET);
  assign word_sel     = gen_addr[2 +: WSEL_W];
  // The SRAM line fetch uses the raw CPU address, not the offset one.
  assign aligned_wide = line_align(64'(bus.address), LINE_OFF_W);
  assign fill_addr    = aligned_wide[ADDR_W-1:0];
  assign fill_word    = bus.SRAM_Read_Data[word_sel*DATA_W +: DATA_W];

  assign bus.CacheAddress = gen_addr[CACHE_ADDR_W+1:2];

  // ----------------------------------------------------------- write buffer
  logic               wb_push;
  logic               wb_pop;
  logic [ENTRY_W-1:0] wb_head;
  logic               wb_full;
  logic               wb_empty;
  logic [CNT_W-1:0]   wb_count;

  write_buffer_fifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (wb_push),
    .pop       (wb_pop),
    .push_data ({bus.address, bus.writeData}),
    .head      (wb_head),
    .full      (wb_full),
    .empty     (wb_empty),
    .count     (wb_count)
  );

  // Bits that are architecturally dropped (byte offset, index bits above the
  // cache, widening headroom) and the occupancy count, kept for visibility.
  logic unused_ok;
  assign unused_ok = ^{gen_addr[1:0], gen_addr[ADDR_W-1:CACHE_ADDR_W+2],
                       aligned_wide[63:ADDR_W], wb_count};

  // --------------------------------------------------------- state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate <= IDLE;
      wstate <= W_IDLE;
    end else begin
      rstate <= rnext;
      wstate <= wnext;
    end
  end

  // ---------------------------------------------------- next state / outputs
  logic                         ready;
  logic [DATA_W-1:0]            read_data;
  logic                         cache_re;
  logic                         cache_we;
  logic                         cache_inv;
  logic [LINE_WORDS*DATA_W-1:0] cache_wdata;
  logic                         sram_re;
  logic                         sram_we;
  logic [ADDR_W-1:0]            sram_addr;
  logic [DATA_W-1:0]            sram_wdata;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves a
    // value unassigned, which would infer a latch.
    rnext       = rstate;
    wnext       = wstate;
    ready       = 1'b0;
    read_data   = '0;
    cache_re    = 1'b0;
    cache_we    = 1'b0;
    cache_inv   = 1'b0;
    cache_wdata = '0;
    sram_re     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    wb_push     = 1'b0;
    wb_pop      = 1'b0;

    if (rst) begin
      // Strobes are forced off while in reset; only an idle bus completes.
      ready = !(bus.MEM_R_EN || bus.MEM_W_EN);
    end else begin
      case (rstate)
        IDLE: begin
          if (bus.MEM_R_EN) begin
            cache_re = 1'b1;
            if (bus.Cache_Hit) begin
              ready     = 1'b1;
              read_data = bus.CacheReadData;
            end else begin
              rnext = WAIT_DRAIN;
            end
          end else if (bus.MEM_W_EN) begin
            // Full is the registered count, so a same-cycle pop does not
            // free a slot until the next cycle.
            if (!wb_full) begin
              wb_push   = 1'b1;
              cache_inv = 1'b1;
              ready     = 1'b1;
            end
          end else begin
            ready = 1'b1;
          end
        end
        WAIT_DRAIN: begin
          // A fetch must observe every earlier write, so wait for the buffer
          // to empty and for any in-flight drain to finish.
          if (wb_empty && wstate == W_IDLE) rnext = FILL;
        end
        FILL: begin
          sram_re   = 1'b1;
          sram_addr = fill_addr;
          if (bus.SRAM_Ready) begin
            cache_we    = 1'b1;
            cache_wdata = bus.SRAM_Read_Data;
            read_data   = fill_word;
            ready       = 1'b1;
            rnext       = IDLE;
          end
        end
        default: rnext = IDLE;
      endcase

      case (wstate)
        W_IDLE: begin
          // Yield the SRAM to an active fill; otherwise start the next drain.
          if (!wb_empty && rstate != FILL) wnext = W_BUSY;
        end
        W_BUSY: begin
          sram_we    = 1'b1;
          sram_addr  = wb_head[ENTRY_W-1:DATA_W];
          sram_wdata = wb_head[DATA_W-1:0];
          if (bus.SRAM_Ready) begin
            wb_pop = 1'b1;
            wnext  = W_IDLE;
          end
        end
        default: wnext = W_IDLE;
      endcase
    end
  end

  assign bus.ready           = ready;
  assign bus.readData        = read_data;
  assign bus.Cache_RE        = cache_re;
  assign bus.Cache_WE        = cache_we;
  assign bus.Cache_Inv       = cache_inv;
  assign bus.CacheWriteData  = cache_wdata;
  assign bus.SRAM_RE         = sram_re;
  assign bus.SRAM_WE         = sram_we;
  assign bus.SRAM_Address    = sram_addr;
  assign bus.SRAM_Write_Data = sram_wdata;

endmodule

// File: tb/tb_cache_controller_wbuf.sv
// Directed self-checking bench for cache_controller_wbuf. Inputs are driven
// 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cache_controller_wbuf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cache_controller_wbuf_if bus ();

  cache_controller_wbuf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.MEM_R_EN       = 1'b0;
    bus.MEM_W_EN       = 1'b0;
    bus.address        = '0;
    bus.writeData      = '0;
    bus.Cache_Hit      = 1'b0;
    bus.CacheReadData  = '0;
    bus.SRAM_Ready     = 1'b0;
    bus.SRAM_Read_Data = '0;
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d);
    bus.MEM_W_EN  = 1'b1;
    bus.address   = a;
    bus.writeData = d;
    tick();
    bus.MEM_W_EN  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL rst_ready_idle: got %b want 1", bus.ready); end
    total++; if ({bus.SRAM_RE, bus.SRAM_WE, bus.Cache_WE, bus.Cache_Inv} !== 4'b0) begin
      bad++; $display("FAIL rst_strobes: got %b want 0000", {bus.SRAM_RE, bus.SRAM_WE, bus.Cache_WE, bus.Cache_Inv}); end
    bus.MEM_R_EN = 1'b1; bus.Cache_Hit = 1'b1; bus.CacheReadData = 32'hFFFF_FFFF;
    #1;
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rst_ready_req: got %b want 0", bus.ready); end
    total++; if ({bus.Cache_RE, bus.readData} !== 33'b0) begin
      bad++; $display("FAIL rst_read_out: got re=%b data=%h want 0", bus.Cache_RE, bus.readData); end
    idle_bus();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_read_hit();
    logic [31:0] addrs [3] = '{32'h0000_040C, 32'h0000_1000, 32'h0000_03FC};
    logic [31:0] datas [3] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
    logic [16:0] cidx  [3] = '{17'h3, 17'h300, 17'h1FFFF};
    for (int i = 0; i < 3; i++) begin
      bus.MEM_R_EN = 1'b1; bus.address = addrs[i];
      bus.Cache_Hit = 1'b1; bus.CacheReadData = datas[i];
      @(negedge clk);
      total++; if (bus.ready !== 1'b1 || bus.readData !== datas[i]) begin
        bad++; $display("FAIL hit%0d_data: got ready=%b data=%h want 1 %h", i, bus.ready, bus.readData, datas[i]); end
      total++; if (bus.CacheAddress !== cidx[i]) begin
        bad++; $display("FAIL hit%0d_index: got %h want %h", i, bus.CacheAddress, cidx[i]); end
      total++; if (bus.Cache_RE !== 1'b1 || bus.SRAM_RE !== 1'b0) begin
        bad++; $display("FAIL hit%0d_strobes: got cre=%b sre=%b want 1 0", i, bus.Cache_RE, bus.SRAM_RE); end
      tick();
    end
    idle_bus();
  endtask

  task automatic test_read_miss();
    bus.MEM_R_EN = 1'b1; bus.address = 32'h40C; bus.Cache_Hit = 1'b0;
    @(negedge clk);
    total++; if (bus.ready !== 1'b0 || bus.Cache_RE !== 1'b1) begin
      bad++; $display("FAIL miss_c0: got ready=%b cre=%b want 0 1", bus.ready, bus.Cache_RE); end
    tick();
    @(negedge clk);
    total++; if (bus.ready !== 1'b0 || bus.SRAM_RE !== 1'b0) begin
      bad++; $display("FAIL miss_drain: got ready=%b sre=%b want 0 0", bus.ready, bus.SRAM_RE); end
    tick();
    @(negedge clk);
    total++; if (bus.SRAM_RE !== 1'b1 || bus.SRAM_Address !== 32'h408 || bus.ready !== 1'b0) begin
      bad++; $display("FAIL miss_fill: got sre=%b addr=%h ready=%b want 1 408 0", bus.SRAM_RE, bus.SRAM_Address, bus.ready); end
    tick();
    bus.SRAM_Ready = 1'b1; bus.SRAM_Read_Data = {32'h2222_2222, 32'h1111_1111};
    @(negedge clk);
    total++; if (bus.Cache_WE !== 1'b1 || bus.CacheWriteData !== {32'h2222_2222, 32'h1111_1111}) begin
      bad++; $display("FAIL miss_cachewe: got we=%b line=%h want 1 2222222211111111", bus.Cache_WE, bus.CacheWriteData); end
    total++; if (bus.ready !== 1'b1 || bus.readData !== 32'h2222_2222) begin
      bad++; $display("FAIL miss_data: got ready=%b data=%h want 1 22222222", bus.ready, bus.readData); end
    tick();
    idle_bus();
    @(negedge clk);
    total++; if (bus.SRAM_RE !== 1'b0 || bus.ready !== 1'b1) begin
      bad++; $display("FAIL miss_return_idle: got sre=%b ready=%b want 0 1", bus.SRAM_RE, bus.ready); end
    tick();
  endtask

  task automatic test_posted_writes();
    int acc = 0;
    for (int i = 0; i < 4; i++) begin
      bus.MEM_W_EN = 1'b1; bus.address = 32'h600 + 32'(4 * i); bus.writeData = 32'h100 + 32'(i);
      @(negedge clk);
      if (bus.ready === 1'b1 && bus.Cache_Inv === 1'b1) acc++;
      tick();
    end
    total++; if (acc != 4) begin bad++; $display("FAIL post_accept: got %0d want 4", acc); end
    bus.MEM_W_EN = 1'b1; bus.address = 32'h610; bus.writeData = 32'h104;
    @(negedge clk);
    total++; if (bus.ready !== 1'b0 || bus.Cache_Inv !== 1'b0) begin
      bad++; $display("FAIL post_full: got ready=%b inv=%b want 0 0", bus.ready, bus.Cache_Inv); end
    total++; if (bus.SRAM_WE !== 1'b1 || bus.SRAM_Address !== 32'h600 || bus.SRAM_Write_Data !== 32'h100) begin
      bad++; $display("FAIL post_head: got we=%b addr=%h data=%h want 1 600 100", bus.SRAM_WE, bus.SRAM_Address, bus.SRAM_Write_Data); end
    tick();
    bus.SRAM_Ready = 1'b1;
    @(negedge clk);
    total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL post_pop_cycle: got ready=%b want 0", bus.ready); end
    tick();
    bus.SRAM_Ready = 1'b0;
    @(negedge clk);
    total++; if (bus.ready !== 1'b1 || bus.Cache_Inv !== 1'b1) begin
      bad++; $display("FAIL post_retry: got ready=%b inv=%b want 1 1", bus.ready, bus.Cache_Inv); end
    tick();
    idle_bus();
    bus.SRAM_Ready = 1'b1;
    repeat (12) tick();
    bus.SRAM_Ready = 1'b0;
    @(negedge clk);
    total++; if (bus.SRAM_WE !== 1'b0) begin bad++; $display("FAIL post_drained: got we=%b want 0", bus.SRAM_WE); end
    tick();
  endtask

  task automatic test_drain_order();
    logic [31:0] exp_a [3] = '{32'h500, 32'h504, 32'h508};
    logic [31:0] exp_d [3] = '{32'hA, 32'hB, 32'hC};
    logic [31:0] got_a [3];
    logic [31:0] got_d [3];
    int n = 0, wc = 0, overlap = 0;
    for (int i = 0; i < 3; i++) push_write(exp_a[i], exp_d[i]);
    idle_bus();
    for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
      bus.SRAM_Ready = 1'b0;
      if (bus.SRAM_RE && bus.SRAM_WE) overlap++;
      if (bus.SRAM_WE) begin
        wc++;
        if (wc == 3) begin
          got_a[n] = bus.SRAM_Address; got_d[n] = bus.SRAM_Write_Data;
          n++; wc = 0; bus.SRAM_Ready = 1'b1;
        end
      end
      tick();
    end
    bus.SRAM_Ready = 1'b0;
    total++; if (n != 3) begin bad++; $display("FAIL drain_count: got %0d want 3 (timeout)", n); end
    total++; if (overlap != 0) begin bad++; $display("FAIL drain_overlap: got %0d want 0", overlap); end
    for (int i = 0; i < n; i++) begin
      total++; if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        bad++; $display("FAIL drain_%0d: got %h/%h want %h/%h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
    end
  endtask

  task automatic test_miss_behind_writes();
    int pops = 0, re_pops = -1;
    bit done = 0;
    logic [31:0] re_addr = '0;
    logic [31:0] rdata = '0;
    logic        rdy = 1'b0;
    logic        both = 1'b0;
    push_write(32'h700, 32'h1);
    push_write(32'h704, 32'h2);
    bus.MEM_R_EN = 1'b1; bus.address = 32'h408; bus.Cache_Hit = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      bus.SRAM_Ready = 1'b0;
      if (bus.SRAM_RE && bus.SRAM_WE) both = 1'b1;
      if (bus.SRAM_WE) begin
        bus.SRAM_Ready = 1'b1; pops++;
      end else if (bus.SRAM_RE) begin
        re_pops = pops; re_addr = bus.SRAM_Address;
        bus.SRAM_Ready = 1'b1; bus.SRAM_Read_Data = {32'h4444_4444, 32'h3333_3333};
        @(negedge clk);
        rdata = bus.readData; rdy = bus.ready; done = 1;
      end
      tick();
    end
    idle_bus();
    total++; if (!done) begin bad++; $display("FAIL mbw_fill: got no fill want fill (timeout)"); end
    total++; if (re_pops != 2 || both !== 1'b0) begin
      bad++; $display("FAIL mbw_order: got pops=%0d both=%b want 2 0", re_pops, both); end
    total++; if (re_addr !== 32'h408 || rdata !== 32'h3333_3333 || rdy !== 1'b1) begin
      bad++; $display("FAIL mbw_data: got addr=%h data=%h ready=%b want 408 33333333 1", re_addr, rdata, rdy); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int stale = 0, acc = 0;
    // Reset while filling.
    bus.MEM_R_EN = 1'b1; bus.address = 32'h40C; bus.Cache_Hit = 1'b0;
    tick(); tick();
    @(negedge clk);
    total++; if (bus.SRAM_RE !== 1'b1) begin bad++; $display("FAIL rmid_in_fill: got %b want 1", bus.SRAM_RE); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.SRAM_RE !== 1'b0 || bus.ready !== 1'b0) begin
      bad++; $display("FAIL rmid_fill_drop: got sre=%b ready=%b want 0 0", bus.SRAM_RE, bus.ready); end
    idle_bus();
    tick();
    rst = 1'b0;
    // Reset with three buffered writes.
    for (int i = 0; i < 3; i++) push_write(32'h800 + 32'(4 * i), 32'h55 + 32'(i));
    tick();
    @(negedge clk);
    total++; if (bus.SRAM_WE !== 1'b1) begin bad++; $display("FAIL rmid_in_busy: got %b want 1", bus.SRAM_WE); end
    #1 rst = 1'b1;
    #1;
    total++; if (bus.SRAM_WE !== 1'b0) begin bad++; $display("FAIL rmid_busy_drop: got %b want 0", bus.SRAM_WE); end
    tick();
    rst = 1'b0;
    bus.SRAM_Ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.SRAM_WE) stale++;
    end
    total++; if (stale != 0 || bus.ready !== 1'b1) begin
      bad++; $display("FAIL rmid_discard: got stale=%0d ready=%b want 0 1", stale, bus.ready); end
    tick();
    bus.SRAM_Ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.MEM_W_EN = 1'b1; bus.address = 32'h900 + 32'(4 * i); bus.writeData = 32'(i);
      @(negedge clk);
      if (bus.ready === 1'b1) acc++;
      tick();
    end
    idle_bus();
    total++; if (acc != 4) begin bad++; $display("FAIL rmid_count_zero: got %0d accepted want 4", acc); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_bus();
    test_reset();
    test_read_hit();
    test_read_miss();
    test_posted_writes();
    test_drain_order();
    test_miss_behind_writes();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
